// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline definitions for the stall/flush sequencer:
// sequencer state encoding and the canonical NOP instruction.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } pstall_state_t;

  // addi x0, x0, 0 -- written into IF/ID when it is flushed
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Wide enough for the largest legal memory timeout
  localparam int unsigned WAIT_CNT_W = 16;

endpackage

// File: rtl/pipe_stall_ctrl_wait_cnt.sv
// Loadable wait counter for outstanding data-memory accesses;
// timeout flags when the count has reached its limit.
module pstall_wait_cnt
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic timeout
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MAX);
  localparam logic [WAIT_CNT_W-1:0] ONE   = WAIT_CNT_W'(1);

  logic [WAIT_CNT_W-1:0] cnt;

  assign timeout = (cnt == LIMIT);

  // Load 1 on entry; count up, never stepping past the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= ONE;
    end else if (inc && !timeout) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer with memory-timeout halt.
// Optional perf counters: define PIPE_STALL_PERF_CNT_EN.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hazard_stall_i,
  input  logic branch_taken_i,
  input  logic mem_req_i,
  input  logic mem_ack_i,
  output logic pc_write_o,
  output logic ifid_write_o,
  output logic ifid_flush_o,
  output logic idex_write_o,
  output logic idex_noop_o,
  output logic exmem_write_o,
  output logic memwb_noop_o,
  output logic halt_o
`ifdef PIPE_STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
`endif
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 65535 || CNT_W < 1)
  begin : g_bad_param
    $error("pipe_stall_ctrl: illegal MEM_TIMEOUT or CNT_W");
  end

  pstall_state_t state;

  logic halted;
  logic freeze;
  logic load_use;
  logic br_flush;
  logic wait_load;
  logic wait_inc;
  logic timeout;

  assign halted = (state == HALT);

  // Frozen while MEM waits: first cycle is seen in RUN,
  // the rest in MEMWAIT until the ack arrives.
  assign freeze = ((state == RUN) && mem_req_i && !mem_ack_i)
               || ((state == MEMWAIT) && !mem_ack_i);

  assign load_use = !halted && !freeze && hazard_stall_i;

  assign br_flush = !halted && !freeze
                 && !hazard_stall_i && branch_taken_i;

  assign wait_load = (state == RUN) && mem_req_i && !mem_ack_i;
  assign wait_inc  = (state == MEMWAIT) && !mem_ack_i;

  assign halt_o = halted;

  pstall_wait_cnt #(
    .MAX (MEM_TIMEOUT)
  ) u_wait_cnt (
    .clk     (clk_i),
    .rst     (rst_i),
    .load    (wait_load),
    .inc     (wait_inc),
    .timeout (timeout)
  );

  // Sequencer: HALT follows a MEMWAIT cycle at the limit
  // with no ack, and only reset leaves it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_req_i && !mem_ack_i) state <= MEMWAIT;
        end
        MEMWAIT: begin
          if (mem_ack_i)    state <= RUN;
          else if (timeout) state <= HALT;
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

  // Control decode: halt > freeze > load-use > branch
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_write_o  = 1'b1;
    idex_noop_o   = 1'b0;
    exmem_write_o = 1'b1;
    memwb_noop_o  = 1'b0;
    unique case (1'b1)
      halted: begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_write_o  = 1'b0;
        exmem_write_o = 1'b0;
        idex_noop_o   = 1'b1;
        memwb_noop_o  = 1'b1;
      end
      freeze: begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_write_o  = 1'b0;
        exmem_write_o = 1'b0;
        memwb_noop_o  = 1'b1;
      end
      load_use: begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        idex_noop_o  = 1'b1;
      end
      br_flush: begin
        ifid_flush_o = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PIPE_STALL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  assign stall_cycles_o = stall_q;
  assign flush_count_o  = flush_q;

  // Perf counters; none of the step conditions hold in HALT
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (freeze || load_use) stall_q <= stall_q + CNT_ONE;
      if (ifid_flush_o)       flush_q <= flush_q + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (MEM_TIMEOUT=4).
// Perf-counter checks run when PIPE_STALL_PERF_CNT_EN is defined.
module tb_pipe_stall_ctrl;

  // {pc_w, ifid_w, ifid_flush, idex_w, idex_noop,
  //  exmem_w, memwb_noop, halt}
  localparam logic [7:0] DEF = 8'b1101_0100;
  localparam logic [7:0] LU  = 8'b0001_1100;
  localparam logic [7:0] BR  = 8'b1111_0100;
  localparam logic [7:0] FRZ = 8'b0000_0010;
  localparam logic [7:0] HLT = 8'b0000_1011;

  typedef struct packed {
    logic [3:0] stim;  // {haz, br, req, ack}
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic haz = 1'b0;
  logic br  = 1'b0;
  logic req = 1'b0;
  logic ack = 1'b0;

  logic pc_w, ifid_w, ifid_fl, idex_w;
  logic idex_nop, exmem_w, memwb_nop, halt;

`ifdef PIPE_STALL_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  vec_t tbl [16];

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (32)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .hazard_stall_i (haz),
    .branch_taken_i (br),
    .mem_req_i      (req),
    .mem_ack_i      (ack),
    .pc_write_o     (pc_w),
    .ifid_write_o   (ifid_w),
    .ifid_flush_o   (ifid_fl),
    .idex_write_o   (idex_w),
    .idex_noop_o    (idex_nop),
    .exmem_write_o  (exmem_w),
    .memwb_noop_o   (memwb_nop),
    .halt_o         (halt)
`ifdef PIPE_STALL_PERF_CNT_EN
    ,
    .stall_cycles_o (stall_cnt),
    .flush_count_o  (flush_cnt)
`endif
  );

  function automatic logic [7:0] outs();
    return {pc_w, ifid_w, ifid_fl, idex_w,
            idex_nop, exmem_w, memwb_nop, halt};
  endfunction

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, got, exp);
  endtask

  task automatic drive(input logic [3:0] s);
    {haz, br, req, ack} = s;
  endtask

  // Drive just after an edge, check mid-cycle, then step
  task automatic apply(input string name,
                       input logic [3:0] s,
                       input logic [7:0] exp);
    drive(s);
    #2;
    check(name, {24'd0, outs()}, {24'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(4'b0000);
    rst = 1'b1;
    #2;
    check("reset_outs", {24'd0, outs()}, {24'd0, DEF});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{4'b0000, DEF};
    tbl[1]  = '{4'b1000, LU};
    tbl[2]  = '{4'b0000, DEF};
    tbl[3]  = '{4'b1100, LU};
    tbl[4]  = '{4'b0100, BR};
    tbl[5]  = '{4'b0110, FRZ};
    tbl[6]  = '{4'b0110, FRZ};
    tbl[7]  = '{4'b0110, FRZ};
    tbl[8]  = '{4'b0111, BR};
    tbl[9]  = '{4'b0011, DEF};
    tbl[10] = '{4'b0001, DEF};
    tbl[11] = '{4'b0000, DEF};
    tbl[12] = '{4'b1011, LU};
    tbl[13] = '{4'b0110, FRZ};
    tbl[14] = '{4'b1011, LU};
    tbl[15] = '{4'b0000, DEF};

    #1;
    do_reset();
`ifdef PIPE_STALL_PERF_CNT_EN
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_flush_cnt", flush_cnt, 32'd0);
`endif

    for (int i = 0; i < 16; i++)
      apply($sformatf("row%0d", i), tbl[i].stim, tbl[i].exp);

    // Ack arriving on the last allowed MEMWAIT cycle
    do_reset();
    for (int i = 0; i < 4; i++)
      apply($sformatf("ack_lim_frz%0d", i), 4'b0010, FRZ);
    apply("ack_lim_rel", 4'b0011, DEF);
    apply("ack_lim_run", 4'b0000, DEF);

    // No ack: RUN freeze plus 4 MEMWAIT cycles, then HALT
    do_reset();
    for (int i = 0; i < 5; i++)
      apply($sformatf("to_frz%0d", i), 4'b0010, FRZ);
    apply("halt0", 4'b0000, HLT);
    apply("halt1", 4'b1111, HLT);
    apply("halt2", 4'b0011, HLT);
    do_reset();
    apply("post_halt_run", 4'b0000, DEF);

    // Reset in the 2nd MEMWAIT cycle
    apply("mw_frz0", 4'b0010, FRZ);
    apply("mw_frz1", 4'b0010, FRZ);
    drive(4'b0010);
    #2;
    check("mw_frz2", {24'd0, outs()}, {24'd0, FRZ});
    rst = 1'b1;
    drive(4'b0000);
    #1;
    check("mw_rst_outs", {24'd0, outs()}, {24'd0, DEF});
`ifdef PIPE_STALL_PERF_CNT_EN
    check("mw_rst_stall", stall_cnt, 32'd0);
    check("mw_rst_flush", flush_cnt, 32'd0);
`endif
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    apply("mw_after", 4'b0000, DEF);
    apply("mw_after_br", 4'b0100, BR);

`ifdef PIPE_STALL_PERF_CNT_EN
    do_reset();
    apply("pc_lu", 4'b1000, LU);
    apply("pc_frz0", 4'b0010, FRZ);
    apply("pc_frz1", 4'b0010, FRZ);
    apply("pc_rel", 4'b0011, DEF);
    apply("pc_br0", 4'b0100, BR);
    apply("pc_br1", 4'b0100, BR);
    apply("pc_br2", 4'b0100, BR);
    check("perf_stall", stall_cnt, 32'd3);
    check("perf_flush", flush_cnt, 32'd3);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
